// File: rtl/cpu_inta_sequencer.sv
// CPU-side 8086 interrupt-acknowledge initiator: issues two active-low INTA_
// pulses to the PIC, captures the vector on the second, and hands it to the CPU.
module cpu_inta_sequencer #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INT,
    input  logic       IF_EN,
    input  logic [7:0] DATA_IN,
    input  logic       VECTOR_ACK,
    output logic       INTA_,
    output logic [7:0] VECTOR,
    output logic       VECTOR_VALID,
    output logic       BUSY,
    output logic [1:0] PULSE_CNT
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW    = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        P1_LOW = 3'd1,
        GAP    = 3'd2,
        P2_LOW = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t          state_reg,  state_next;
    logic [CW-1:0]   cnt_reg,    cnt_next;
    logic            inta_reg,   inta_next;
    logic [7:0]      vector_reg, vector_next;
    logic            valid_reg,  valid_next;
    logic [1:0]      pcnt_reg,   pcnt_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            inta_reg   <= 1'b1;
            vector_reg <= 8'h00;
            valid_reg  <= 1'b0;
            pcnt_reg   <= 2'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            inta_reg   <= inta_next;
            vector_reg <= vector_next;
            valid_reg  <= valid_next;
            pcnt_reg   <= pcnt_next;
        end
    end

    // Each timed state loads its length on entry and leaves when the count reaches 1.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        vector_next = vector_reg;
        valid_next  = valid_reg;
        pcnt_next   = pcnt_reg;

        case (state_reg)
            IDLE: begin
                if (INT && IF_EN) begin
                    state_next = P1_LOW;
                    cnt_next   = PULSE_LD;
                end
            end
            P1_LOW: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next = GAP;
                    cnt_next   = GAP_LD;
                    pcnt_next  = 2'd1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next = P2_LOW;
                    cnt_next   = PULSE_LD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            P2_LOW: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next  = HOLD;
                    cnt_next    = '0;
                    vector_next = DATA_IN;
                    valid_next  = 1'b1;
                    pcnt_next   = 2'd2;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            HOLD: begin
                if (VECTOR_ACK) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                    pcnt_next  = 2'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // INTA_ is registered from the next state so it changes only on a clock edge.
        inta_next = !((state_next == P1_LOW) || (state_next == P2_LOW));
    end

    assign INTA_        = inta_reg;
    assign VECTOR       = vector_reg;
    assign VECTOR_VALID = valid_reg;
    assign PULSE_CNT    = pcnt_reg;
    assign BUSY         = (state_reg != IDLE);

endmodule

// File: doc/cpu_inta_sequencer.md
# cpu_inta_sequencer

Processor-side interrupt-acknowledge initiator for the 8259 PIC design, 8086 mode. It watches the PIC's INT output and generates the two active-low INTA_ pulses the Control_Unit expects. On the second pulse it captures the 8-bit vector the PIC drives onto the data bus, then presents that vector to the CPU model with a valid/ack handshake. It serves as the bench/system partner for Control_Unit in integration simulations.

## Interface
- PULSE_W, 2: cycles INTA_ is held low per pulse; legal range ≥1.
- GAP_W, 2: cycles INTA_ is held high between the two pulses; legal range ≥1.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- INT  in  1  interrupt request from PIC, active-high.
- IF_EN  in  1  CPU interrupt-enable flag; new sequences start only when 1.
- DATA_IN  in  8  PIC data bus, sampled only at vector capture.
- VECTOR_ACK  in  1  CPU accepts the presented vector.
- INTA_  out  1  acknowledge to PIC, active-low.
- VECTOR  out  8  captured interrupt vector.
- VECTOR_VALID  out  1  VECTOR holds an unconsumed vector.
- BUSY  out  1  high in any state except IDLE.
- PULSE_CNT  out  2  INTA_ pulses completed in the current sequence: 0, 1 or 2.

## Operation
- States: IDLE, P1_LOW, GAP, P2_LOW, HOLD.
- Reset values: state IDLE, INTA_=1, VECTOR=8'h00, VECTOR_VALID=0, BUSY=0, PULSE_CNT=0, internal counter 0.
- IDLE: if INT=1 and IF_EN=1 at an edge, go to P1_LOW, drive INTA_=0, load counter. Otherwise stay.
- P1_LOW: INTA_=0 for exactly PULSE_W cycles, then go to GAP. PULSE_CNT becomes 1 on that edge.
- GAP: INTA_=1 for exactly GAP_W cycles, then go to P2_LOW.
- P2_LOW: INTA_=0 for exactly PULSE_W cycles. On the edge ending the last low cycle, all of the following happen together:
  - VECTOR ← DATA_IN;
  - INTA_ → 1;
  - VECTOR_VALID → 1;
  - PULSE_CNT → 2;
  - go to HOLD.
- HOLD: VECTOR and VECTOR_VALID are stable. VECTOR_ACK=1 at an edge clears VECTOR_VALID and PULSE_CNT and returns to IDLE. VECTOR keeps its last value.
- INT falling, or IF_EN falling, after IDLE has left does not abort the sequence. The PIC supplies the spurious IR7 vector; the block captures whatever DATA_IN shows.
- VECTOR_ACK is ignored in every state except HOLD.
- Counter width is $clog2(max(PULSE_W,GAP_W)+1). It counts down to 1, and the terminal count triggers the transition.
- A level-held INT after ack starts a new sequence, because IDLE re-samples it; this is the intended behaviour.

## Timing
- Let edge k be the IDLE edge that samples INT=1 and IF_EN=1.
- INTA_ is low after edges k … k+PULSE_W−1.
- INTA_ is high for GAP_W cycles.
- INTA_ is low again for PULSE_W cycles.
- The vector is captured at edge k+2·PULSE_W+GAP_W, and VECTOR_VALID is visible from then on. With the defaults this is edge k+6.
- Ack at edge m with VECTOR_VALID=1: VECTOR_VALID=0 and IDLE after m. The earliest next sequence start is edge m+1, with INTA_ low after m+1.
- INTA_ is registered and glitch-free; no combinational path from any input to INTA_.
- RST=1 at any edge, including mid-pulse: all outputs take their reset values after that edge, and INTA_ goes high immediately. RST takes priority over INT and VECTOR_ACK.
- INT and VECTOR_ACK both high in HOLD: the ack is honoured, IDLE is entered, and the new INT is sampled at the following edge.

## Test plan
- Defaults, DATA_IN=8'h48, INT raised at edge k → INTA_ low for cycles k..k+1, high k+2..k+3, low k+4..k+5. At edge k+6: VECTOR=8'h48, VECTOR_VALID=1, PULSE_CNT=2. BUSY high from k to ack.
- IF_EN=0 with INT=1 for 10 cycles → INTA_ stays 1, BUSY=0. Raising IF_EN starts the sequence on the next edge.
- INT dropped during GAP, DATA_IN=8'h4F → the second pulse still occurs, and VECTOR=8'h4F is captured.
- RST pulsed during P2_LOW → INTA_=1, VECTOR=8'h00, VECTOR_VALID=0, PULSE_CNT=0 after that edge. The next INT then produces a full, fresh two-pulse sequence.
- VECTOR_ACK held low for 20 cycles in HOLD with INT still high → no further INTA_ pulses, and VECTOR is stable. Ack → exactly one new sequence begins the edge after IDLE is entered.
- PULSE_W=1, GAP_W=3, DATA_IN=8'h20 → low 1 cycle, high 3, low 1. VECTOR_VALID at edge k+5.
